// File: rtl/program_loader_pkg.sv
// Shared types and constants for the framed program loader.
package program_loader_pkg;

  // Frame parser states; 3-bit encoding.
  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_LEN  = 3'd3,
    ST_DATA = 3'd4,
    ST_CHK  = 3'd5,
    ST_EVAL = 3'd6
  } state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] CMD_WRITE    = 8'h01;
  localparam logic [7:0] CMD_RUN      = 8'h02;
  localparam logic [7:0] CMD_HALT     = 8'h03;

  // Length byte 0 encodes a full 256-byte burst.
  function automatic logic [8:0] decode_len(input logic [7:0] len);
    return (len == 8'h00) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input plus instruction-memory write port of the loader.
interface program_loader_if;
  logic [7:0] inData;
  logic       inValid;
  logic       inReady;
  logic [7:0] memAddr;
  logic [7:0] memDataWrite;
  logic       memWrite;

  // Byte source / memory side.
  modport master (
    output inData, inValid,
    input  inReady, memAddr, memDataWrite, memWrite
  );

  // Loader side.
  modport slave (
    input  inData, inValid,
    output inReady, memAddr, memDataWrite, memWrite
  );
endinterface

// File: rtl/program_loader.sv
// Framed byte-stream loader: writes instruction memory and gates CPU run.
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE     = SYNC_DEFAULT,
  parameter bit         HOLD_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              resetN,
  program_loader_if.slave   bus,
  output logic              cpuRun,
  output logic              frameOk,
  output logic              frameErr
);

  state_e     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] ptr_q, ptr_d;
  logic [8:0] cnt_q, cnt_d;
  logic       in_ready_q, in_ready_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_data_q, mem_data_d;
  logic       mem_write_q, mem_write_d;
  logic       cpu_run_q, cpu_run_d;
  logic       frame_ok_q, frame_ok_d;
  logic       frame_err_q, frame_err_d;

  logic       acc;
  logic [7:0] din;

  assign acc = bus.inValid & in_ready_q;
  assign din = bus.inData;

  // Next-state: one parser step per accepted byte, EVAL is a fixed bubble.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    sum_d       = sum_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_write_d = 1'b0;
    cpu_run_d   = cpu_run_q;
    frame_ok_d  = 1'b0;
    frame_err_d = frame_err_q;

    unique case (state_q)
      ST_HUNT: if (acc && din == SYNC_BYTE) begin
        state_d     = ST_CMD;
        sum_d       = 8'h00;
        frame_err_d = 1'b0;
      end
      ST_CMD: if (acc) begin
        sum_d = sum_q + din;
        cmd_d = din;
        if (din == CMD_WRITE) begin
          state_d   = ST_ADDR;
          cpu_run_d = 1'b0;   // hold the CPU while its memory is rewritten
        end else if (din == CMD_RUN || din == CMD_HALT) begin
          state_d = ST_CHK;
        end else begin
          state_d     = ST_HUNT;
          frame_err_d = 1'b1;
        end
      end
      ST_ADDR: if (acc) begin
        sum_d   = sum_q + din;
        ptr_d   = din;
        state_d = ST_LEN;
      end
      ST_LEN: if (acc) begin
        sum_d   = sum_q + din;
        cnt_d   = decode_len(din);
        state_d = ST_DATA;
      end
      ST_DATA: if (acc) begin
        sum_d       = sum_q + din;
        mem_write_d = 1'b1;
        mem_addr_d  = ptr_q;
        mem_data_d  = din;
        ptr_d       = ptr_q + 8'd1;   // wraps FF -> 00
        cnt_d       = cnt_q - 9'd1;
        if (cnt_q == 9'd1) state_d = ST_CHK;
      end
      ST_CHK: if (acc) begin
        sum_d   = sum_q + din;
        state_d = ST_EVAL;
      end
      ST_EVAL: begin
        state_d = ST_HUNT;
        if (sum_q == 8'h00) begin
          frame_ok_d = 1'b1;
          if (cmd_q == CMD_RUN)       cpu_run_d = 1'b1;
          else if (cmd_q == CMD_HALT) cpu_run_d = 1'b0;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // Registered ready: drops for exactly the EVAL cycle.
    in_ready_d = (state_d != ST_EVAL);
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= ST_HUNT;
      cmd_q       <= 8'h00;
      sum_q       <= 8'h00;
      ptr_q       <= 8'h00;
      cnt_q       <= 9'd0;
      in_ready_q  <= 1'b0;
      mem_addr_q  <= 8'h00;
      mem_data_q  <= 8'h00;
      mem_write_q <= 1'b0;
      cpu_run_q   <= ~HOLD_AT_RESET;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      sum_q       <= sum_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_write_q <= mem_write_d;
      cpu_run_q   <= cpu_run_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.inReady      = in_ready_q;
  assign bus.memAddr      = mem_addr_q;
  assign bus.memDataWrite = mem_data_q;
  assign bus.memWrite     = mem_write_q;
  assign cpuRun           = cpu_run_q;
  assign frameOk          = frame_ok_q;
  assign frameErr         = frame_err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames, wrap, bad checksum, junk, gaps, 256-byte burst, reset.
module tb_program_loader;

  logic clk = 1'b0;
  logic resetN;
  logic cpuRun, frameOk, frameErr;

  always #5 clk = ~clk;

  program_loader_if bus();

  program_loader #(.SYNC_BYTE(8'hA5), .HOLD_AT_RESET(1'b1)) dut (
    .clk      (clk),
    .resetN   (resetN),
    .bus      (bus),
    .cpuRun   (cpuRun),
    .frameOk  (frameOk),
    .frameErr (frameErr)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_n = 0;
  int ok_n = 0;
  logic [7:0] wr_a[$];
  logic [7:0] wr_d[$];
  int         wr_c[$];

  // Log every memory write and frameOk pulse, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (bus.memWrite === 1'b1) begin
      wr_a.push_back(bus.memAddr);
      wr_d.push_back(bus.memDataWrite);
      wr_c.push_back(cyc);
      wr_n++;
    end
    if (frameOk === 1'b1) ok_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte and hold it until an edge where inReady was high.
  task automatic send(input logic [7:0] b);
    logic rdy;
    int n;
    bus.inData  = b;
    bus.inValid = 1'b1;
    rdy = 1'b0;
    n = 0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy = bus.inReady;
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy) check("send_timeout", {31'b0, rdy}, 32'd1);
  endtask

  task automatic idle(input int n);
    bus.inValid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int base, ok0, bad;
  int cov[256];

  initial begin
    resetN = 1'b0;
    bus.inValid = 1'b0;
    bus.inData  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_inReady", bus.inReady, 0);
    check("rst_memWrite", bus.memWrite, 0);
    check("rst_memAddr", bus.memAddr, 0);
    check("rst_memData", bus.memDataWrite, 0);
    check("rst_frameOk", frameOk, 0);
    check("rst_frameErr", frameErr, 0);
    check("rst_cpuRun", cpuRun, 0);
    resetN = 1'b1;
    @(posedge clk);
    #1;
    check("rel_inReady", bus.inReady, 1);

    // WRITE 3 bytes at 10; CHK = -(01+10+03+11+22+33) = 86
    base = wr_n; ok0 = ok_n;
    send(8'hA5); send(8'h01); send(8'h10); send(8'h03);
    send(8'h11); send(8'h22); send(8'h33); send(8'h86);
    check("t1_eval_not_ready", bus.inReady, 0);
    idle(3);
    check("t1_wr_count", wr_n - base, 3);
    check("t1_a0", wr_a[base], 8'h10);   check("t1_d0", wr_d[base], 8'h11);
    check("t1_a1", wr_a[base+1], 8'h11); check("t1_d1", wr_d[base+1], 8'h22);
    check("t1_a2", wr_a[base+2], 8'h12); check("t1_d2", wr_d[base+2], 8'h33);
    check("t1_consec01", wr_c[base+1] - wr_c[base], 1);
    check("t1_consec12", wr_c[base+2] - wr_c[base+1], 1);
    check("t1_ok", ok_n - ok0, 1);
    check("t1_cpuRun", cpuRun, 0);
    check("t1_err", frameErr, 0);

    // RUN
    ok0 = ok_n;
    send(8'hA5); send(8'h02); send(8'hFE);
    idle(3);
    check("t2_ok", ok_n - ok0, 1);
    check("t2_cpuRun", cpuRun, 1);

    // WRITE wrapping FF->00; CHK = -(01+FF+02+AA+BB) = 99
    base = wr_n; ok0 = ok_n;
    send(8'hA5); send(8'h01);
    check("t3_cpu_hold_on_cmd", cpuRun, 0);
    send(8'hFF); send(8'h02); send(8'hAA); send(8'hBB); send(8'h99);
    idle(3);
    check("t3_wr_count", wr_n - base, 2);
    check("t3_a0", wr_a[base], 8'hFF);   check("t3_d0", wr_d[base], 8'hAA);
    check("t3_a1", wr_a[base+1], 8'h00); check("t3_d1", wr_d[base+1], 8'hBB);
    check("t3_ok", ok_n - ok0, 1);

    // Bad checksum: write still lands, error sticky until next SYNC
    base = wr_n; ok0 = ok_n;
    send(8'hA5); send(8'h01); send(8'h20); send(8'h01); send(8'h55); send(8'h00);
    idle(3);
    check("t4_wr_count", wr_n - base, 1);
    check("t4_a0", wr_a[base], 8'h20); check("t4_d0", wr_d[base], 8'h55);
    check("t4_err", frameErr, 1);
    check("t4_no_ok", ok_n - ok0, 0);
    check("t4_cpuRun", cpuRun, 0);
    send(8'hA5);
    check("t4_err_clr", frameErr, 0);
    send(8'h02); send(8'hFE);
    idle(3);
    check("t4_run_ok", ok_n - ok0, 1);
    check("t4_run_cpu", cpuRun, 1);

    // Junk then unknown command
    base = wr_n; ok0 = ok_n;
    send(8'h00); send(8'hA4);
    check("t5_junk_no_err", frameErr, 0);
    send(8'hA5); send(8'h07);
    idle(2);
    check("t5_err", frameErr, 1);
    check("t5_no_wr", wr_n - base, 0);
    check("t5_cpu_keep", cpuRun, 1);
    send(8'hA5); send(8'h03); send(8'hFD);   // HALT; proves parser back in HUNT
    idle(3);
    check("t5_halt_ok", ok_n - ok0, 1);
    check("t5_halt_cpu", cpuRun, 0);

    // Gaps mid-DATA, SYNC value as payload; CHK = -(01+40+02+A5+88) = 90
    base = wr_n; ok0 = ok_n;
    send(8'hA5); send(8'h01); send(8'h40); send(8'h02);
    idle(3);
    check("gap_no_early_wr", wr_n - base, 0);
    send(8'hA5);
    idle(2);
    send(8'h88); send(8'h90);
    idle(3);
    check("gap_wr_count", wr_n - base, 2);
    check("gap_a0", wr_a[base], 8'h40);   check("gap_d0", wr_d[base], 8'hA5);
    check("gap_a1", wr_a[base+1], 8'h41); check("gap_d1", wr_d[base+1], 8'h88);
    check("gap_ok", ok_n - ok0, 1);

    // LEN=0: 256 bytes data=i at addr i; CHK = -(01+00+00+80) = 7F
    base = wr_n; ok0 = ok_n;
    send(8'hA5); send(8'h01); send(8'h00); send(8'h00);
    for (int i = 0; i < 256; i++) send(i[7:0]);
    send(8'h7F);
    idle(3);
    check("t6_wr_count", wr_n - base, 256);
    for (int i = 0; i < 256; i++) cov[i] = 0;
    bad = 0;
    for (int i = base; i < wr_n; i++) begin
      cov[wr_a[i]]++;
      if (wr_d[i] !== wr_a[i]) bad++;
    end
    for (int i = 0; i < 256; i++) if (cov[i] != 1) bad++;
    check("t6_cover_bad", bad, 0);
    check("t6_ok", ok_n - ok0, 1);
    check("t6_err", frameErr, 0);

    // Reset mid-DATA after a RUN: writes stop, cpuRun back to held
    send(8'hA5); send(8'h02); send(8'hFE);
    idle(3);
    check("t7_pre_cpu", cpuRun, 1);
    base = wr_n;
    send(8'hA5); send(8'h01); send(8'h80); send(8'h10);
    send(8'hC1); send(8'hC2); send(8'hC3);
    bus.inData = 8'hEE;
    resetN = 1'b0;
    @(posedge clk);
    #1;
    check("t7_rst_memWrite", bus.memWrite, 0);
    check("t7_rst_cpu", cpuRun, 0);
    check("t7_rst_ready", bus.inReady, 0);
    resetN = 1'b1;
    idle(3);
    check("t7_wr_count", wr_n - base, 3);
    check("t7_last_a", wr_a[wr_n-1], 8'h82);
    check("t7_ready", bus.inReady, 1);
    ok0 = ok_n;
    send(8'hA5); send(8'h02); send(8'hFE);
    idle(3);
    check("t7_recover_ok", ok_n - ok0, 1);
    check("t7_recover_cpu", cpuRun, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
